// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: mips_16 fetch stage owning the PC and the IF/ID pipeline register
// Ports: pc drives the instruction ROM address, instruction is the ROM's same-cycle data;
//   stall, branch_taken/branch_target and halt steer fetching; if_id_instr, if_id_pc_plus1
//   and if_id_valid feed decode; fetch_state reports BOOT=0, RUN=1, HALTED=2.
// Define IF_PERF_COUNTERS_EN to add the saturating fetch_count and stall_count outputs.
module instruction_fetch_stage #(
  parameter int                  PC_WIDTH    = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  BOOT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [PC_WIDTH-1:0] pc,
  input  logic [15:0]         instruction,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                halt,
  output logic [15:0]         if_id_instr,
  output logic [PC_WIDTH-1:0] if_id_pc_plus1,
  output logic                if_id_valid,
  output logic [1:0]          fetch_state
`ifdef IF_PERF_COUNTERS_EN
  ,
  output logic [15:0]         fetch_count,
  output logic [15:0]         stall_count
`endif
);
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALTED = 2'd2} state_t;
  localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYCLES - 1);
  state_t              state, state_n;
  logic [3:0]          cnt, cnt_n;
  logic [PC_WIDTH-1:0] pc_reg, pc_n, pc_inc, pc1_n;
  logic [15:0]         instr_n;
  logic                valid_n, go;
  assign pc          = pc_reg;
  assign pc_inc      = pc_reg + PC_WIDTH'(1);
  assign fetch_state = state;
  assign go          = !branch_taken && !stall && !halt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state          <= BOOT;
      cnt            <= BOOT_INIT;
      pc_reg         <= RESET_PC;
      if_id_instr    <= '0;
      if_id_pc_plus1 <= '0;
      if_id_valid    <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      pc_reg         <= pc_n;
      if_id_instr    <= instr_n;
      if_id_pc_plus1 <= pc1_n;
      if_id_valid    <= valid_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pc_n    = pc_reg;
    instr_n = if_id_instr;
    pc1_n   = if_id_pc_plus1;
    valid_n = if_id_valid;
    case (state)
      BOOT: begin
        cnt_n   = (cnt == 4'd0) ? cnt : cnt - 4'd1;
        state_n = (cnt != 4'd0) ? BOOT : halt ? HALTED : RUN;
        instr_n = '0;
        pc1_n   = '0;
        valid_n = 1'b0;
      end
      RUN: begin
        state_n = (!branch_taken && !stall && halt) ? HALTED : RUN;
        pc_n    = branch_taken ? branch_target : go ? pc_inc : pc_reg;
        // only a stall without a branch preserves IF/ID; branch and halt load a bubble
        if (branch_taken || !stall) begin
          instr_n = go ? instruction : '0;
          pc1_n   = go ? pc_inc : '0;
          valid_n = go;
        end
      end
      HALTED: begin
        state_n = halt ? HALTED : RUN;
        pc_n    = branch_taken ? branch_target : pc_reg;
        instr_n = '0;
        pc1_n   = '0;
        valid_n = 1'b0;
      end
      default: begin
        state_n = BOOT;
        cnt_n   = BOOT_INIT;
      end
    endcase
  end
`ifdef IF_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (state == RUN && go && !(&fetch_count)) fetch_count <= fetch_count + 16'd1;
      if (state == RUN && stall && !branch_taken && !(&stall_count)) stall_count <= stall_count + 16'd1;
    end
`endif
endmodule
